// File: rtl/apb3_bridge_pkg.sv
// Shared types for the APB3 bridge: FSM state encoding, default request record, select decode.
package apb3_bridge_pkg;

    localparam int SEL_MAX_W = 5;
    localparam int NSLV_MAX  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  sel;
    } apb_req_t;

    function automatic logic [NSLV_MAX-1:0] sel_onehot(input logic [SEL_MAX_W-1:0] idx);
        logic [NSLV_MAX-1:0] one;
        one = {{(NSLV_MAX-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/apb3_bridge_fsm_if.sv
// Request/response handshake and APB3 fabric bundle; master = bridge view, slave = environment view.
interface apb3_bridge_fsm_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 4,
    parameter int SEL_W  = $clog2(NSLV) + 1
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [ADDR_W-1:0]      req_addr;
    logic [DATA_W-1:0]      req_wdata;
    logic [SEL_W-1:0]       req_sel;
    logic                   rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic [NSLV-1:0]        psel;
    logic                   penable;
    logic                   pwrite;
    logic [ADDR_W-1:0]      paddr;
    logic [DATA_W-1:0]      pwdata;
    logic [NSLV-1:0]        pready;
    logic [NSLV*DATA_W-1:0] prdata;
    logic [NSLV-1:0]        pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_sel,
        input  pready, prdata, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_sel,
        output pready, prdata, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_req_skid.sv
// Single-entry pending buffer with bypass: presents the stored request if full, else the incoming one.
// Latency: zero on the bypass path; a stored entry is presented the cycle after it is loaded.
// Backpressure: caller must only assert in_vld while pend_vld is low; take drains the presented request.
module apb_req_skid
    import apb3_bridge_pkg::*;
#(
    parameter type req_t = apb_req_t
) (
    input  logic clk,
    input  logic rst,
    input  logic in_vld,
    input  req_t in_dat,
    input  logic take,
    output logic pend_vld,
    output logic out_vld,
    output req_t out_dat
);
    logic pend_vld_q, pend_vld_d;
    req_t pend_q, pend_d;

    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;
        if (take && pend_vld_q) begin
            pend_vld_d = 1'b0;
        end
        if (in_vld && !take) begin
            pend_vld_d = 1'b1;
            pend_d     = in_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
        end
    end

    assign pend_vld = pend_vld_q;
    assign out_vld  = pend_vld_q || in_vld;
    assign out_dat  = pend_vld_q ? pend_q : in_dat;
endmodule

// File: rtl/apb3_bridge_fsm.sv
// APB3 master sequencer over NSLV one-hot slaves; APB_TIMEOUT_EN adds an ACCESS-cycle timeout.
// Latency: accept at T -> SETUP T+1 -> ACCESS T+2 -> rsp_valid T+3; 2 cycles per back-to-back transfer.
// Backpressure: req_ready low while the pending slot is full; rsp_valid is a one-cycle strobe, never stalled.
module apb3_bridge_fsm
    import apb3_bridge_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NSLV        = 4,
    parameter int SEL_W       = $clog2(NSLV) + 1,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst,
    apb3_bridge_fsm_if.master bus
);
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [SEL_W-1:0]  sel;
    } req_t;

    localparam logic [SEL_W-1:0] NSLV_SEL = SEL_W'(NSLV);

    apb_state_e        state_q, state_d;
    logic [NSLV-1:0]   psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              acc_vld;
    req_t              acc_dat;
    logic              pend_vld;
    logic              src_vld;
    req_t              src_dat;
    logic              src_ok;
    logic              slot;
    logic              done;
    logic              take;
    logic              slv_rdy;
    logic              slv_err;
    logic [DATA_W-1:0] slv_rdata;
    logic              tmo_hit;

    assign bus.req_ready = rst && !pend_vld;
    assign acc_vld       = bus.req_valid && bus.req_ready;
    assign acc_dat       = '{write: bus.req_write, addr: bus.req_addr,
                             wdata: bus.req_wdata, sel: bus.req_sel};

    apb_req_skid #(.req_t(req_t)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (acc_vld),
        .in_dat   (acc_dat),
        .take     (take),
        .pend_vld (pend_vld),
        .out_vld  (src_vld),
        .out_dat  (src_dat)
    );

    always_comb begin
        slv_rdy   = 1'b0;
        slv_err   = 1'b0;
        slv_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (psel_q[i]) begin
                slv_rdy   = bus.pready[i];
                slv_err   = bus.pslverr[i];
                slv_rdata = bus.prdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counter is zero in the first ACCESS cycle since SETUP always precedes it.
    assign tmo_hit   = (state_q == ACCESS) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
    assign tmo_cnt_d = (state_q == ACCESS) ? tmo_cnt_q + TMO_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (!rst) tmo_cnt_q <= '0;
        else      tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign done   = (state_q == ACCESS) && (slv_rdy || tmo_hit);
    assign slot   = (state_q == IDLE) || done;
    assign src_ok = src_dat.sel < NSLV_SEL;
    // A bad select arriving on a completion edge would collide with that completion's response,
    // so it is left in the pending slot and answered from IDLE one cycle later.
    assign take   = slot && src_vld && (src_ok || (state_q == IDLE));

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        case (state_q)
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (done) begin
                    state_d     = IDLE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !slv_rdy || slv_err;
                    rsp_rdata_d = (!pwrite_q && slv_rdy && !slv_err) ? slv_rdata : '0;
                end
            end
            default: ;
        endcase

        if (take) begin
            if (src_ok) begin
                state_d   = SETUP;
                psel_d    = NSLV'(sel_onehot(SEL_MAX_W'(src_dat.sel)));
                penable_d = 1'b0;
                pwrite_d  = src_dat.write;
                paddr_d   = src_dat.addr;
                pwdata_d  = src_dat.wdata;
            end else begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_rdata_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb3_bridge_fsm.sv
// Bench for apb3_bridge_fsm: transaction scoreboard plus an APB slave model driving scripted wait/error behaviour.
module tb_apb3_bridge_fsm;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int NSLV   = 4;
    localparam int SEL_W  = $clog2(NSLV) + 1;
    localparam int TMO    = 8;

    typedef struct {
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [SEL_W-1:0]  s;
        logic              err;
        logic [DATA_W-1:0] rd;
        int                waits;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    txn_t        apb_q[$];
    logic [32:0] rsp_q[$];
    int          rsp_cyc[$];

    apb3_bridge_fsm_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV), .SEL_W(SEL_W)) bus ();

    apb3_bridge_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV), .SEL_W(SEL_W),
                      .TIMEOUT_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected response derived from the request's scripted slave behaviour.
    function automatic logic [32:0] expect_rsp(input txn_t t);
        logic bad;
        bad = (int'(t.s) >= NSLV) || t.err;
`ifdef APB_TIMEOUT_EN
        if (t.waits >= TMO) bad = 1'b1;
`endif
        if (bad)  return {1'b1, 32'h0};
        if (t.w)  return {1'b0, 32'h0};
        return {1'b0, t.rd};
    endfunction

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int s, input logic err, input logic [31:0] rd,
                        input int waits, output int nwait);
        txn_t t;
        t.w = w; t.a = a; t.d = d; t.s = SEL_W'(s); t.err = err; t.rd = rd; t.waits = waits;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_sel   = t.s;
        nwait = 0;
        while (!bus.req_ready && nwait < 300) begin
            @(posedge clk); #1;
            nwait++;
        end
        if (!bus.req_ready) chk("accept_timeout", bus.req_ready, 1);
        if (s < NSLV) apb_q.push_back(t);
        rsp_q.push_back(expect_rsp(t));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while (rsp_q.size() != 0 && n < lim) begin
            @(posedge clk); #1;
            n++;
        end
        if (rsp_q.size() != 0) chk("drain_timeout", rsp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Response scoreboard and APB slave model, both acting on the falling edge.
    initial begin
        txn_t        cur;
        logic [32:0] e;
        logic [3:0]  one;
        int          idx;
        int          waits_left;
        one = 4'b0001;
        idx = 0;
        waits_left = 0;
        cur = '{w: 1'b0, a: '0, d: '0, s: '0, err: 1'b0, rd: '0, waits: 0};
        forever begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", bus.rsp_valid, 0);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_err", bus.rsp_err, e[32]);
                    chk("rsp_rdata", bus.rsp_rdata, e[31:0]);
                    rsp_cyc.push_back(cyc);
                end
            end
            for (int i = 0; i < NSLV; i++) bus.prdata[i*DATA_W +: DATA_W] = $urandom;
            bus.pready  = NSLV'($urandom);
            bus.pslverr = NSLV'($urandom);
            if (bus.psel != '0 && !bus.penable) begin
                if (apb_q.size() == 0) begin
                    chk("apb_unexpected", bus.psel, 0);
                end else begin
                    cur = apb_q.pop_front();
                    idx = int'(cur.s);
                    waits_left = cur.waits;
                    chk("setup_psel", bus.psel, one << cur.s);
                    chk("setup_paddr", bus.paddr, cur.a);
                    chk("setup_pwrite", bus.pwrite, cur.w);
                    chk("setup_pwdata", bus.pwdata, cur.d);
                end
            end else if (bus.psel != '0 && bus.penable) begin
                chk("access_psel", bus.psel, one << cur.s);
                chk("access_paddr", bus.paddr, cur.a);
                if (waits_left == 0) begin
                    bus.pready[idx]  = 1'b1;
                    bus.pslverr[idx] = cur.err;
                    bus.prdata[idx*DATA_W +: DATA_W] = cur.rd;
                end else begin
                    bus.pready[idx] = 1'b0;
                    waits_left--;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int nw, n, k, base;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_sel   = '0;
        bus.pready    = '0;
        bus.pslverr   = '0;
        bus.prdata    = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_psel", bus.psel, 0);
        chk("rst_penable", bus.penable, 0);
        chk("rst_paddr", bus.paddr, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Zero-wait write to slave 1.
        send(1'b1, 32'h10, 32'hA5A5A5A5, 1, 1'b0, 32'h0, 0, nw);
        chk("zw_setup_psel", bus.psel, 4'b0010);
        chk("zw_setup_penable", bus.penable, 0);
        @(posedge clk); #1;
        chk("zw_access_penable", bus.penable, 1);
        @(posedge clk); #1;
        chk("zw_rsp_valid", bus.rsp_valid, 1);
        chk("zw_rsp_err", bus.rsp_err, 0);
        drain(50);

        // Read from slave 2 with three wait states.
        send(1'b0, 32'h200, 32'h0, 2, 1'b0, 32'h12345678, 3, nw);
        n = 0; k = 0;
        while (!bus.rsp_valid && k < 40) begin
            if (bus.penable) n++;
            @(posedge clk); #1;
            k++;
        end
        chk("ws_access_cycles", n, 4);
        chk("ws_rdata", bus.rsp_rdata, 32'h12345678);
        drain(50);

        // Three back-to-back zero-wait requests.
        base = rsp_cyc.size();
        send(1'b1, 32'h300, 32'h1111, 0, 1'b0, 32'h0, 0, nw);
        send(1'b0, 32'h304, 32'h2222, 3, 1'b0, 32'hBEEF0001, 0, nw);
        send(1'b1, 32'h308, 32'h3333, 1, 1'b0, 32'h0, 0, nw);
        chk("b2b_ready_stall", nw, 1);
        drain(50);
        chk("b2b_rsp_count", rsp_cyc.size() - base, 3);
        if (rsp_cyc.size() - base == 3) begin
            chk("b2b_spacing0", rsp_cyc[base+1] - rsp_cyc[base], 2);
            chk("b2b_spacing1", rsp_cyc[base+2] - rsp_cyc[base+1], 2);
        end

        // Slave error on slave 0 read.
        send(1'b0, 32'h40, 32'h0, 0, 1'b1, 32'hDEADBEEF, 0, nw);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("slverr_rsp_valid", bus.rsp_valid, 1);
        chk("slverr_rsp_err", bus.rsp_err, 1);
        chk("slverr_rsp_rdata", bus.rsp_rdata, 0);
        drain(50);

        // Out-of-range select.
        send(1'b0, 32'h50, 32'h0, NSLV, 1'b0, 32'h0, 0, nw);
        chk("badsel_psel", bus.psel, 0);
        chk("badsel_rsp_valid", bus.rsp_valid, 1);
        chk("badsel_rsp_err", bus.rsp_err, 1);
        drain(50);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            send($urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, NSLV + 1),
                 ($urandom_range(0, 7) == 0), $urandom, $urandom_range(0, 3), nw);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain(3000);

        // Reset during ACCESS with a pending entry.
        send(1'b0, 32'h600, 32'hCAFEF00D, 3, 1'b0, 32'h0, 20, nw);
        send(1'b1, 32'h604, 32'h55AA55AA, 1, 1'b0, 32'h0, 0, nw);
        chk("mrst_in_access", bus.penable, 1);
        chk("mrst_pend_full", bus.req_ready, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        apb_q.delete();
        rsp_q.delete();
        chk("mrst_psel", bus.psel, 0);
        chk("mrst_penable", bus.penable, 0);
        chk("mrst_paddr", bus.paddr, 0);
        chk("mrst_pwdata", bus.pwdata, 0);
        chk("mrst_pwrite", bus.pwrite, 0);
        chk("mrst_rsp_valid", bus.rsp_valid, 0);
        chk("mrst_req_ready", bus.req_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_ready_after", bus.req_ready, 1);
        repeat (6) @(posedge clk);
        #1;
        chk("mrst_no_relaunch", bus.psel, 0);
        send(1'b1, 32'h700, 32'h77777777, 2, 1'b0, 32'h0, 1, nw);
        drain(50);

`ifdef APB_TIMEOUT_EN
        send(1'b0, 32'h800, 32'h0, 2, 1'b0, 32'h0, 1000, nw);
        n = 0; k = 0;
        while (!bus.rsp_valid && k < 60) begin
            if (bus.penable) n++;
            @(posedge clk); #1;
            k++;
        end
        chk("tmo_access_cycles", n, TMO);
        chk("tmo_rsp_err", bus.rsp_err, 1);
        drain(50);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
